// File: rtl/tape_ram.sv
// tape_ram: tape memory for the Turing-machine datapath.
// Holds 2**ADDR_SPACE cells plus a head pointer. It accepts one
// read/write/move command per cycle and returns the cell under the new
// head on the following cycle. The whole tape self-clears to BLANK after
// reset or on a clr request.
// Build option: define TAPE_WRAP_EN to make the head wrap modulo DEPTH.
// By default the head saturates at both ends and sets the sticky edge_hit flag.
module tape_ram #(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ADDR_SPACE = 14,
  parameter logic [DATA_WIDTH-1:0]  BLANK      = '0,
  parameter logic [ADDR_SPACE-1:0]  HOME       = {1'b1, {(ADDR_SPACE-1){1'b0}}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [1:0]            cmd_move,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_SPACE-1:0] head,
  output logic                  busy,
  output logic                  edge_hit
);

  localparam int DEPTH = 2 ** ADDR_SPACE;
  localparam logic [ADDR_SPACE-1:0] LAST = '1;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_SPACE-1:0] clr_cnt;
  logic [ADDR_SPACE-1:0] moved_head;
  logic                  clipped;
  logic                  accept;
  logic                  move_right;
  logic                  move_left;

  assign accept     = cmd_valid & cmd_ready;
  assign move_right = (cmd_move == 2'b01);
  assign move_left  = (cmd_move == 2'b10);

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs: CLEAR sweeps the tape, RUN serves commands.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == LAST) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        cmd_ready = 1'b1;
        if (clr) begin
          next_state = S_CLEAR;
        end
      end
      default: begin
        next_state = S_CLEAR;
      end
    endcase
  end

`ifdef TAPE_WRAP_EN
  // Head arithmetic wraps modulo DEPTH, so a move is never clipped.
  always_comb begin
    moved_head = head;
    clipped    = 1'b0;
    if (move_right) begin
      moved_head = head + 1'b1;
    end else if (move_left) begin
      moved_head = head - 1'b1;
    end
  end
`else
  // Head arithmetic saturates at both tape ends and flags the clipped move.
  always_comb begin
    moved_head = head;
    clipped    = 1'b0;
    if (move_right) begin
      if (head == LAST) begin
        clipped = 1'b1;
      end else begin
        moved_head = head + 1'b1;
      end
    end else if (move_left) begin
      if (head == '0) begin
        clipped = 1'b1;
      end else begin
        moved_head = head - 1'b1;
      end
    end
  end
`endif

  // Tape storage: the clear sweep owns the write port in CLEAR, commands own it in RUN.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= BLANK;
    end else if (accept && cmd_write) begin
      mem[head] <= cmd_wdata;
    end
  end

  // Head, response and sticky flag; a same-cell write is forwarded into the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      head      <= HOME;
      rsp_valid <= 1'b0;
      rsp_data  <= BLANK;
      edge_hit  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (accept) begin
        head <= moved_head;
        if (cmd_write && (moved_head == head)) begin
          rsp_data <= cmd_wdata;
        end else begin
          rsp_data <= mem[moved_head];
        end
        if (clipped) begin
          edge_hit <= 1'b1;
        end
      end
      if ((state == S_RUN) && clr) begin
        clr_cnt  <= '0;
        head     <= HOME;
        edge_hit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tape_ram.sv
// tb_tape_ram: directed bench for tape_ram with an 8-bit by 16-cell tape.
// Expectations follow TAPE_WRAP_EN the same way the design does.
module tb_tape_ram;

  localparam logic [1:0] STAY  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic [1:0] cmd_move;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] head;
  logic       busy;
  logic       edge_hit;

  int n_checks;
  int n_fail;
  int clear_cycles;

  tape_ram #(
    .DATA_WIDTH(8),
    .ADDR_SPACE(4),
    .BLANK(8'h00),
    .HOME(4'd8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata),
    .cmd_move(cmd_move),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .head(head),
    .busy(busy),
    .edge_hit(edge_hit)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [7:0] wdata,
                               input logic [1:0] move, input logic clear_req);
    cmd_valid = valid;
    cmd_write = write;
    cmd_wdata = wdata;
    cmd_move  = move;
    clr       = clear_req;
    @(negedge clk);
  endtask

  task automatic driveIdle();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_wdata = 8'h00;
    cmd_move  = STAY;
    clr       = 1'b0;
  endtask

  task automatic waitClear(output int cycles);
    driveIdle();
    cycles = 0;
    while (!cmd_ready && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_head"}, 32'(head), 32'd8);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'h00);
    checkOutput({tag, "_edge_hit"}, 32'(edge_hit), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    driveIdle();

    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    waitClear(clear_cycles);
    checkOutput("reset_clear_cycles", 32'(clear_cycles), 32'd16);
    checkOutput("reset_done_busy", 32'(busy), 32'd0);
    checkOutput("reset_done_head", 32'(head), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, LEFT, 1'b0);
      checkOutput("sweep_left_head", 32'(head), 32'(8 - i));
      checkOutput("sweep_left_data", 32'(rsp_data), 32'h00);
      checkOutput("sweep_left_valid", 32'(rsp_valid), 32'd1);
    end
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, RIGHT, 1'b0);
      checkOutput("sweep_right_head", 32'(head), 32'(i));
      checkOutput("sweep_right_data", 32'(rsp_data), 32'h00);
    end
    checkOutput("sweep_edge_hit", 32'(edge_hit), 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, LEFT, 1'b0);
    end
    checkOutput("sweep_return_head", 32'(head), 32'd8);

    applyStimulus(1'b1, 1'b1, 8'hA5, RIGHT, 1'b0);
    checkOutput("a5_valid", 32'(rsp_valid), 32'd1);
    checkOutput("a5_data", 32'(rsp_data), 32'h00);
    checkOutput("a5_head", 32'(head), 32'd9);
    applyStimulus(1'b0, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("idle_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_hold_data", 32'(rsp_data), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, LEFT, 1'b0);
    checkOutput("a5_readback_data", 32'(rsp_data), 32'hA5);
    checkOutput("a5_readback_head", 32'(head), 32'd8);

    applyStimulus(1'b1, 1'b1, 8'h3C, STAY, 1'b0);
    checkOutput("fwd_3c_data", 32'(rsp_data), 32'h3C);
    checkOutput("fwd_3c_valid", 32'(rsp_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h7E, STAY, 1'b0);
    checkOutput("fwd_7e_data", 32'(rsp_data), 32'h7E);
    checkOutput("fwd_7e_valid", 32'(rsp_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("fwd_idle_valid", 32'(rsp_valid), 32'd0);
    checkOutput("fwd_idle_hold", 32'(rsp_data), 32'h7E);
    applyStimulus(1'b1, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("fwd_reread", 32'(rsp_data), 32'h7E);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, RIGHT, 1'b0);
    end
    checkOutput("at_end_head", 32'(head), 32'd15);
    applyStimulus(1'b1, 1'b1, 8'h11, RIGHT, 1'b0);
`ifdef TAPE_WRAP_EN
    checkOutput("wrap_right_head", 32'(head), 32'd0);
    checkOutput("wrap_right_data", 32'(rsp_data), 32'h00);
    checkOutput("wrap_right_edge", 32'(edge_hit), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, LEFT, 1'b0);
    checkOutput("wrap_left_head", 32'(head), 32'd15);
    checkOutput("wrap_left_data", 32'(rsp_data), 32'h11);
    checkOutput("wrap_left_edge", 32'(edge_hit), 32'd0);
`else
    checkOutput("clip_right_head", 32'(head), 32'd15);
    checkOutput("clip_right_data", 32'(rsp_data), 32'h11);
    checkOutput("clip_right_edge", 32'(edge_hit), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("clip_edge_sticky", 32'(edge_hit), 32'd1);
`endif

    applyStimulus(1'b1, 1'b1, 8'h22, LEFT, 1'b1);
    checkOutput("clr_cmd_valid", 32'(rsp_valid), 32'd1);
    checkOutput("clr_cmd_data", 32'(rsp_data), 32'h00);
    checkOutput("clr_head", 32'(head), 32'd8);
    checkOutput("clr_busy", 32'(busy), 32'd1);
    checkOutput("clr_ready", 32'(cmd_ready), 32'd0);
    checkOutput("clr_edge", 32'(edge_hit), 32'd0);
    waitClear(clear_cycles);
    checkOutput("clr_clear_cycles", 32'(clear_cycles), 32'd16);
    applyStimulus(1'b1, 1'b0, 8'h00, RIGHT, 1'b0);
    checkOutput("clr_wiped_head", 32'(head), 32'd9);
    checkOutput("clr_wiped_data", 32'(rsp_data), 32'h00);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, LEFT, 1'b0);
    end
    checkOutput("at_zero_head", 32'(head), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h5A, LEFT, 1'b0);
`ifdef TAPE_WRAP_EN
    checkOutput("wrap_zero_head", 32'(head), 32'd15);
    checkOutput("wrap_zero_data", 32'(rsp_data), 32'h00);
    checkOutput("wrap_zero_edge", 32'(edge_hit), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, RIGHT, 1'b0);
    checkOutput("wrap_back_head", 32'(head), 32'd0);
    checkOutput("wrap_back_data", 32'(rsp_data), 32'h5A);
`else
    checkOutput("clip_left_head", 32'(head), 32'd0);
    checkOutput("clip_left_data", 32'(rsp_data), 32'h5A);
    checkOutput("clip_left_edge", 32'(edge_hit), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, RIGHT, 1'b0);
    checkOutput("clip_left_after_head", 32'(head), 32'd1);
    checkOutput("clip_left_after_edge", 32'(edge_hit), 32'd1);
`endif

    applyStimulus(1'b1, 1'b1, 8'h66, STAY, 1'b0);
    checkOutput("pre_reset_data", 32'(rsp_data), 32'h66);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'h77;
    cmd_move  = RIGHT;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    driveIdle();
    #1;
    checkResetValues("cmd_reset");
    @(negedge clk);
    rst_n = 1'b1;
    waitClear(clear_cycles);
    checkOutput("cmd_reset_clear_cycles", 32'(clear_cycles), 32'd16);
    applyStimulus(1'b1, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("cmd_reset_wiped_data", 32'(rsp_data), 32'h00);
    checkOutput("cmd_reset_wiped_head", 32'(head), 32'd8);

    applyStimulus(1'b1, 1'b1, 8'h99, STAY, 1'b1);
    checkOutput("mid_clear_entry_busy", 32'(busy), 32'd1);
    checkOutput("mid_clear_entry_data", 32'(rsp_data), 32'h99);
    driveIdle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("clear_reset");
    @(negedge clk);
    rst_n = 1'b1;
    waitClear(clear_cycles);
    checkOutput("clear_reset_clear_cycles", 32'(clear_cycles), 32'd16);
    checkOutput("final_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, STAY, 1'b0);
    checkOutput("final_data", 32'(rsp_data), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
